// File: rtl/adder_mask_reducer_pkg.sv
// Shared constants and FSM state type for the Adder_mask reducer slice.
package adder_mask_pkg;
  localparam int NUM_MACRO  = 16;
  localparam int OUT_CH     = 512;
  localparam int BIT_OUT_CH = $clog2(OUT_CH);
  localparam int BIT_PSUM   = 16;
  localparam int BIT_SUM    = BIT_PSUM + $clog2(NUM_MACRO);
  localparam int BIT_IDX    = $clog2(NUM_MACRO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/adder_mask_reducer_masked_sum_tree.sv
// Combinational signed sum of the partial sums selected by a group bit-vector.
module masked_sum_tree
  import adder_mask_pkg::*;
(
  input  logic [NUM_MACRO*BIT_PSUM-1:0] psum,
  input  logic [NUM_MACRO-1:0]          group,
  output logic signed [BIT_SUM-1:0]     sum
);

  logic [BIT_PSUM-1:0] term_s;

  // Accumulate the sign-extended members of the group.
  always_comb begin
    sum    = '0;
    term_s = '0;
    for (int j = 0; j < NUM_MACRO; j++) begin
      term_s = psum[j*BIT_PSUM +: BIT_PSUM];
      if (group[j]) begin
        sum = sum + $signed({{(BIT_SUM-BIT_PSUM){term_s[BIT_PSUM-1]}}, term_s});
      end else begin
        sum = sum;
      end
    end
  end

endmodule

// File: rtl/adder_mask_reducer.sv
// Latches one set of partial sums and emits one summed result per filter group.
// Optional build macro: ADDER_MASK_CHECK_EN adds the mask_err consistency flag.
module adder_mask_reducer
  import adder_mask_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_MACRO*BIT_OUT_CH-1:0]  WHICH_FILTER,
  input  logic [NUM_MACRO*NUM_MACRO-1:0]   Adder_mask,
  input  logic [NUM_MACRO*BIT_PSUM-1:0]    PSUM,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIT_OUT_CH-1:0]            out_filter,
  output logic signed [BIT_SUM-1:0]        out_sum,
  output logic                             out_last
`ifdef ADDER_MASK_CHECK_EN
  ,
  output logic                             mask_err
`endif
);

  localparam logic [NUM_MACRO-1:0] ONE_HOT0 = {{(NUM_MACRO-1){1'b0}}, 1'b1};

  state_t                          state_r, state_nxt_s;
  logic [NUM_MACRO*BIT_OUT_CH-1:0] wf_r;
  logic [NUM_MACRO*NUM_MACRO-1:0]  mask_r;
  logic [NUM_MACRO*BIT_PSUM-1:0]   psum_r;
  logic [NUM_MACRO-1:0]            pending_r, pending_nxt_s;
  logic [NUM_MACRO-1:0]            group_r, group_s;
  logic [BIT_IDX-1:0]              leader_s;
  logic signed [BIT_SUM-1:0]       sum_s;
  logic                            out_valid_r, out_last_r;
  logic [BIT_OUT_CH-1:0]           out_filter_r;
  logic signed [BIT_SUM-1:0]       out_sum_r;
  logic                            accept_s, take_s, more_s;

  assign accept_s      = (state_r == IDLE) && in_valid;
  assign take_s        = (state_r == EMIT) && out_valid_r && out_ready;
  assign pending_nxt_s = take_s ? (pending_r & ~group_r) : pending_r;
  assign more_s        = |pending_nxt_s;

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = out_valid_r;
  assign out_filter = out_filter_r;
  assign out_sum    = out_sum_r;
  assign out_last   = out_last_r;

  // Leader is the lowest still-pending macro; the group is always computed
  // from the post-handshake pending set so back-to-back emission works.
  always_comb begin
    leader_s = '0;
    for (int i = NUM_MACRO - 1; i >= 0; i--) begin
      if (pending_nxt_s[i]) begin
        leader_s = BIT_IDX'(i);
      end else begin
        leader_s = leader_s;
      end
    end
    group_s = (mask_r[leader_s*NUM_MACRO +: NUM_MACRO] | (ONE_HOT0 << leader_s)) & pending_nxt_s;
  end

  masked_sum_tree u_sum_tree (
    .psum  (psum_r),
    .group (group_s),
    .sum   (sum_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = LOAD;
        else          state_nxt_s = IDLE;
      end
      LOAD: state_nxt_s = EMIT;
      EMIT: begin
        if (take_s && !more_s) state_nxt_s = IDLE;
        else                   state_nxt_s = EMIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Input capture, pending bookkeeping and registered group outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_r         <= '0;
      mask_r       <= '0;
      psum_r       <= '0;
      pending_r    <= '0;
      group_r      <= '0;
      out_valid_r  <= 1'b0;
      out_filter_r <= '0;
      out_sum_r    <= '0;
      out_last_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wf_r      <= WHICH_FILTER;
            mask_r    <= Adder_mask;
            psum_r    <= PSUM;
            pending_r <= '1;
          end
        end
        LOAD: begin
          group_r      <= group_s;
          out_sum_r    <= sum_s;
          out_filter_r <= wf_r[leader_s*BIT_OUT_CH +: BIT_OUT_CH];
          out_last_r   <= ((pending_nxt_s & ~group_s) == '0);
        end
        EMIT: begin
          if (take_s) begin
            pending_r <= pending_nxt_s;
            if (more_s) begin
              group_r      <= group_s;
              out_sum_r    <= sum_s;
              out_filter_r <= wf_r[leader_s*BIT_OUT_CH +: BIT_OUT_CH];
              out_last_r   <= ((pending_nxt_s & ~group_s) == '0);
            end
          end
        end
        default: pending_r <= '0;
      endcase
      // Valid rises on the first EMIT cycle boundary and drops after the last handshake.
      out_valid_r <= (state_r == EMIT) && !(take_s && !more_s);
    end
  end

`ifdef ADDER_MASK_CHECK_EN
  logic mismatch_s, mismatch_r, mask_err_r;

  // Mask bit must equal filter equality for every macro pair.
  always_comb begin
    mismatch_s = 1'b0;
    for (int i = 0; i < NUM_MACRO; i++) begin
      for (int j = 0; j < NUM_MACRO; j++) begin
        if (Adder_mask[i*NUM_MACRO + j] !=
            (WHICH_FILTER[i*BIT_OUT_CH +: BIT_OUT_CH] == WHICH_FILTER[j*BIT_OUT_CH +: BIT_OUT_CH])) begin
          mismatch_s = 1'b1;
        end else begin
          mismatch_s = mismatch_s;
        end
      end
    end
  end

  // Sticky error flag, set one cycle after a bad set is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r <= 1'b0;
      mask_err_r <= 1'b0;
    end else begin
      mismatch_r <= accept_s && mismatch_s;
      mask_err_r <= mask_err_r | mismatch_r;
    end
  end

  assign mask_err = mask_err_r;
`endif

endmodule

// File: tb/tb_adder_mask_reducer.sv
// Directed, table-driven bench for adder_mask_reducer (plus reset and mask-check sequences).
module tb_adder_mask_reducer;
  import adder_mask_pkg::*;

  localparam int NM  = NUM_MACRO;
  localparam int BOC = BIT_OUT_CH;
  localparam int BP  = BIT_PSUM;
  localparam int BS  = BIT_SUM;

  typedef struct {
    logic [NM*BOC-1:0] wf;
    logic [NM*NM-1:0]  mask;
    logic [NM*BP-1:0]  psum;
    int                n;
    logic              toggle;
    logic              noise;
    logic [NM*BOC-1:0] ef;
    logic [NM*BS-1:0]  es;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NM*BOC-1:0]   WHICH_FILTER = '0;
  logic [NM*NM-1:0]    Adder_mask = '0;
  logic [NM*BP-1:0]    PSUM = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [BOC-1:0]      out_filter;
  logic signed [BS-1:0] out_sum;
  logic                out_last;
`ifdef ADDER_MASK_CHECK_EN
  logic                mask_err;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  adder_mask_reducer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .WHICH_FILTER (WHICH_FILTER),
    .Adder_mask   (Adder_mask),
    .PSUM         (PSUM),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_filter   (out_filter),
    .out_sum      (out_sum),
    .out_last     (out_last)
`ifdef ADDER_MASK_CHECK_EN
    ,
    .mask_err     (mask_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t new_vec();
    vec_t t;
    t.wf = '0; t.mask = '0; t.psum = '0; t.n = 0;
    t.toggle = 1'b0; t.noise = 1'b0; t.ef = '0; t.es = '0;
    return t;
  endfunction

  function automatic logic [NM*NM-1:0] identity();
    logic [NM*NM-1:0] m;
    m = '0;
    for (int i = 0; i < NM; i++) m[i*NM + i] = 1'b1;
    return m;
  endfunction

  task automatic run_vec(input int v, input logic chk_err);
    int got;
    int cyc;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    WHICH_FILTER = vecs[v].wf;
    Adder_mask   = vecs[v].mask;
    PSUM         = vecs[v].psum;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    in_valid = vecs[v].noise;
    if (vecs[v].noise) begin
      WHICH_FILTER = ~vecs[v].wf;
      PSUM         = ~vecs[v].psum;
      Adder_mask   = '1;
    end
    @(negedge clk);
    chk("lat_t0_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_t0_ready", {31'd0, in_ready}, 32'd0);
    if (chk_err) begin
`ifdef ADDER_MASK_CHECK_EN
      chk("err_t0", {31'd0, mask_err}, 32'd0);
`endif
    end
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, out_valid}, 32'd0);
    if (chk_err) begin
`ifdef ADDER_MASK_CHECK_EN
      chk("err_t1", {31'd0, mask_err}, 32'd1);
`endif
    end
    got = 0;
    cyc = 0;
    while (got < vecs[v].n && cyc < 100) begin
      @(posedge clk); #1;
      if (vecs[v].noise) in_valid = (got < vecs[v].n - 1);
      out_ready = vecs[v].toggle ? ~out_ready : 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("lat_t2_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        chk($sformatf("v%0d_g%0d_filter", v, got), {23'd0, out_filter}, {23'd0, vecs[v].ef[got*BOC +: BOC]});
        chk($sformatf("v%0d_g%0d_sum", v, got), {12'd0, out_sum}, {12'd0, vecs[v].es[got*BS +: BS]});
        chk($sformatf("v%0d_g%0d_last", v, got), {31'd0, out_last}, {31'd0, (got == vecs[v].n - 1)});
        if (out_ready) got++;
      end
    end
    chk($sformatf("v%0d_count", v), got, vecs[v].n);
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_drain_valid", v), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d_drain_ready", v), {31'd0, in_ready}, 32'd1);
    if (chk_err) begin
`ifdef ADDER_MASK_CHECK_EN
      chk("err_held", {31'd0, mask_err}, 32'd1);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int got;
    int cyc;

    // 0: all filters equal, one group
    t = new_vec(); t.mask = '1; t.n = 1;
    for (int j = 0; j < NM; j++) begin
      t.wf[j*BOC +: BOC] = BOC'(7); t.psum[j*BP +: BP] = BP'(j);
    end
    t.ef[0 +: BOC] = BOC'(7); t.es[0 +: BS] = BS'(120);
    vecs[0] = t;
    // 1: all distinct, identity mask, PSUM = -1
    t = new_vec(); t.mask = identity(); t.n = 16;
    for (int j = 0; j < NM; j++) begin
      t.wf[j*BOC +: BOC] = BOC'(j); t.psum[j*BP +: BP] = {BP{1'b1}};
      t.ef[j*BOC +: BOC] = BOC'(j); t.es[j*BS +: BS] = {BS{1'b1}};
    end
    vecs[1] = t;
    // 2: alternating filters A=3/B=10, toggling out_ready, busy-time stimulus
    t = new_vec(); t.n = 2; t.toggle = 1'b1; t.noise = 1'b1;
    for (int i = 0; i < NM; i++) begin
      t.wf[i*BOC +: BOC] = (i % 2 == 0) ? BOC'(3) : BOC'(10);
      t.psum[i*BP +: BP] = BP'(100);
      for (int j = 0; j < NM; j++) t.mask[i*NM + j] = ((i % 2) == (j % 2));
    end
    t.ef[0 +: BOC] = BOC'(3);  t.es[0 +: BS] = BS'(800);
    t.ef[BOC +: BOC] = BOC'(10); t.es[BS +: BS] = BS'(800);
    vecs[2] = t;
    // 3: row 0 all ones, row 1 = 0x0003 overlapping
    t = new_vec(); t.mask = identity(); t.n = 1;
    t.mask[0 +: NM] = 16'hFFFF; t.mask[NM +: NM] = 16'h0003;
    for (int j = 0; j < NM; j++) begin
      t.wf[j*BOC +: BOC] = BOC'(j + 20); t.psum[j*BP +: BP] = BP'(j + 1);
    end
    t.ef[0 +: BOC] = BOC'(20); t.es[0 +: BS] = BS'(136);
    vecs[3] = t;
    // 4: row 0 = {0,2}, row 1 = {2,3} with diagonal clear
    t = vecs[3]; t.mask = identity(); t.n = 14;
    t.mask[0 +: NM] = 16'h0005; t.mask[NM +: NM] = 16'h000C;
    t.ef = '0; t.es = '0;
    t.ef[0 +: BOC] = BOC'(20); t.es[0 +: BS] = BS'(4);
    t.ef[BOC +: BOC] = BOC'(21); t.es[BS +: BS] = BS'(6);
    for (int j = 4; j < NM; j++) begin
      t.ef[(j-2)*BOC +: BOC] = BOC'(j + 20); t.es[(j-2)*BS +: BS] = BS'(j + 1);
    end
    vecs[4] = t;
    // 5: most negative sum
    t = new_vec(); t.mask = '1; t.n = 1;
    for (int j = 0; j < NM; j++) t.psum[j*BP +: BP] = 16'h8000;
    t.es[0 +: BS] = 20'h80000;
    vecs[5] = t;
    // 6: most positive sum, toggled ready
    t = vecs[5]; t.toggle = 1'b1;
    for (int j = 0; j < NM; j++) begin
      t.psum[j*BP +: BP] = 16'h7FFF; t.wf[j*BOC +: BOC] = 9'h1FF;
    end
    t.ef[0 +: BOC] = 9'h1FF; t.es[0 +: BS] = 20'h7FFF0;
    vecs[6] = t;
    // 7: identity plus stray bit [2][5], filters distinct
    t = new_vec(); t.mask = identity(); t.n = 15;
    t.mask[2*NM + 5] = 1'b1;
    for (int j = 0; j < NM; j++) begin
      t.wf[j*BOC +: BOC] = BOC'(j); t.psum[j*BP +: BP] = BP'(j);
    end
    for (int g = 0; g < 5; g++) begin
      t.ef[g*BOC +: BOC] = BOC'(g); t.es[g*BS +: BS] = (g == 2) ? BS'(7) : BS'(g);
    end
    for (int j = 6; j < NM; j++) begin
      t.ef[(j-1)*BOC +: BOC] = BOC'(j); t.es[(j-1)*BS +: BS] = BS'(j);
    end
    vecs[7] = t;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_filter", {23'd0, out_filter}, 32'd0);
    chk("rst_out_sum", {12'd0, out_sum}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
`ifdef ADDER_MASK_CHECK_EN
    chk("rst_mask_err", {31'd0, mask_err}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(v, 1'b0);

    // Reset while the third of sixteen groups is on the output.
    @(posedge clk); #1;
    WHICH_FILTER = vecs[1].wf; Adder_mask = vecs[1].mask; PSUM = vecs[1].psum;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("rst5_pre_filter", {23'd0, out_filter}, got);
        got++;
      end
    end
    @(negedge clk);
    chk("rst5_third_valid", {31'd0, out_valid}, 32'd1);
    chk("rst5_third_filter", {23'd0, out_filter}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst5_out_filter", {23'd0, out_filter}, 32'd0);
    chk("rst5_out_sum", {12'd0, out_sum}, 32'd0);
    chk("rst5_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(0, 1'b0);

`ifdef ADDER_MASK_CHECK_EN
    run_vec(7, 1'b1);
`else
    run_vec(7, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
